rnn_cell_engine: RTL and testbench
==================================

# rnn_cell_engine

- Parametrised successor to the single-size RNN core: computes h_t = act(b_ih + b_hh + W_x·x_t + W_h·h_{t-1}) for T timesteps.
- Sizes are set by parameters: hidden size, input bits, data width, fraction bits.
- Shares the external weight/result memory over the mce/msel/maddr port using one multiply-accumulate per cycle.
- Pulls binary input vectors over the idata/i_en handshake.

## Interface
- HID, 64, hidden-state length (power of 2, ≥2)
- XW, 32, input vector bits per timestep (power of 2, ≤32)
- DW, 20, signed data width of weights, biases and h
- FW, 16, fraction bits (Q(DW-FW).FW)
- AW, 17, maddr width; must hold {t,h} and {h,k}
- clk  in  1  clock, all flops rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ready  in  1  start request, sampled in IDLE
- idata  in  32  input vector; bit j = x_t[j], bits ≥XW ignored
- mdata_r  in  DW  memory read data
- busy  out  1  high from start until run complete
- i_en  out  1  one-cycle request for next idata
- mce  out  1  memory enable; high while busy
- maddr  out  AW  memory address
- mdata_w  out  DW  write data (valid when msel=101)
- msel  out  3  region: 100 length, 001 b_ih[h], 011 b_hh[h], 000 W_x[h][j] @{h,j}, 010 W_h[h][k] @{h,k}, 101 h_t[h] write @{t,h}

## Operation
- FSM: IDLE → LDT → XIN → BIAS → WX → WH → RND → WR → (BIAS | XIN | IDLE).
- IDLE: busy=0. ready=1 → LDT, busy=1. ready ignored while busy.
- LDT: read msel=100, maddr=0; T = mdata_r (unsigned). T=0 → IDLE, no writes, no i_en.
- XIN: i_en=1 for one cycle; idata captured into x register on the following edge. Preceded by copy h_new→h_old (all HID entries, one cycle).
- Per neuron h, accumulator is cleared first.
  - BIAS: b_ih then b_hh, each added <<FW.
  - WX: addresses j=0..XW-1; W_x[h][j]<<FW added only if x[j]=1.
  - WH: k=0..HID-1; adds W_h[h][k]·h_old[k] as a full 2DW-bit signed product. Skipped entirely when t=0 (h_{-1}=0).
- Accumulator width: 2·DW + clog2(HID+XW+2); never wraps.
- RND: add 2^(FW-1), arithmetic shift right FW (round half up), then apply act.
- WR: msel=101, maddr={t,h}, mdata_w=h_t[h]; stored into h_new[h].
  - h<HID-1 → next neuron.
  - h=HID-1 and t<T-1 → t+1, XIN.
  - t=T-1 → IDLE.
- Idle/between-access outputs: msel holds last value; mdata_w holds last written value.

## Timing
- Synchronous memory: address/msel in cycle n → mdata_r valid in cycle n+1. Reads issued back-to-back, one per cycle.
- Cycles per neuron: 2 + XW + (t>0 ? HID : 0) + 2 (last-data/RND + WR).
- Per timestep: 2 (copy + XIN) + HID·neuron cycles.
- Start: ready seen in IDLE on edge e → busy=1, msel=100 in the cycle after e.
- busy falls on the edge after the final WR cycle; ready may restart the run from the next cycle.
- Reset values: busy=0, i_en=0, mce=0, maddr=0, mdata_w=0, msel=100; h_old, h_new, accumulator, t, h, x = 0.
- reset low mid-run: all outputs go to reset values immediately. No further writes after reset rises; restart requires ready.

## Configuration
- RNN_HTANH_EN defined: act = hard-tanh. Result clipped to [-2^FW, +2^FW] (±1.0; 0x10000 / 0xF0000 at DW=20, FW=16).
- RNN_HTANH_EN undefined: act = linear. Result saturates to [-2^(DW-1), 2^(DW-1)-1].

## Test plan
Parameters HID=2, XW=4, DW=20, FW=16 unless stated; unspecified weights and biases are 0.
- Reset: assert reset mid-WX.
  - Outputs go to busy=0, i_en=0, mce=0, maddr=0, msel=100 without a clock edge.
  - No msel=101 cycle after release.
- Zero length: T=0, ready pulse → exactly one read (msel=100, addr 0); busy high for 2 cycles; no i_en, no write.
- Single step: T=1, x=0101, b_ih[0]=0x08000, W_x[0][0]=0x10000, W_x[0][2]=0x08000, W_x[0][1]=0x10000 (masked).
  - Write @{0,0}: 0x10000 with RNN_HTANH_EN, 0x20000 without.
  - Neuron takes 8 cycles.
- Recurrence: T=2; step 0 gives h_0[0]=0x08000, with x_1=0 and W_h[1][0]=0xF8000.
  - Write @{1,1} = 0xFC000 (-0.25).
  - Step-1 neuron takes 10 cycles.
- Rounding: with h_old[0]=0x00001, W_h[0][0]=0x08000 → h_1[0]=0x00001; with W_h[0][0]=0xF8000 → 0x00000.
- Saturation (linear build): b_ih=b_hh=0x7FFFF → writes 0x7FFFF; both 0x80000 → writes 0x80000.

Source files
------------

// File: rtl/rnn_cell_engine.sv
// rnn_cell_engine
//   Parametrised RNN cell: h_t = act(b_ih + b_hh + W_x*x_t + W_h*h_{t-1})
//   for T timesteps, one multiply-accumulate per cycle against a shared
//   synchronous weight/result memory.
//
// Optional feature macro: RNN_HTANH_EN
//   defined   -> hard-tanh activation, clip to [-2^FW, +2^FW]
//   undefined -> linear activation, saturate to the DW-bit signed range
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   ready    in   start request, sampled in IDLE
//   idata    in   input vector, bit j = x_t[j] (bits >= XW ignored)
//   mdata_r  in   memory read data (one cycle after address)
//   busy     out  high from start until run complete
//   i_en     out  one-cycle request for the next idata
//   mce      out  memory enable, high while busy
//   maddr    out  memory address
//   mdata_w  out  write data (valid when msel = 101)
//   msel     out  memory region select
module rnn_cell_engine #(
  parameter int HID = 64,
  parameter int XW  = 32,
  parameter int DW  = 20,
  parameter int FW  = 16,
  parameter int AW  = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [31:0]   idata,
  input  logic [DW-1:0] mdata_r,
  output logic          busy,
  output logic          i_en,
  output logic          mce,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdata_w,
  output logic [2:0]    msel
);

  localparam int KB  = (HID > 1) ? $clog2(HID) : 1;
  localparam int XB  = (XW > 1) ? $clog2(XW) : 1;
  localparam int CB  = (KB > XB) ? KB : XB;
  localparam int ACW = 2*DW + $clog2(HID + XW + 2);

  localparam logic [3:0] S_IDLE = 4'd0, S_LDT = 4'd1, S_LDW = 4'd2,
                         S_CPY  = 4'd3, S_XIN = 4'd4, S_BIAS = 4'd5,
                         S_WX   = 4'd6, S_WH  = 4'd7, S_RND = 4'd8,
                         S_WR   = 4'd9;

  localparam logic [2:0] M_LEN = 3'b100, M_BIH = 3'b001, M_BHH = 3'b011,
                         M_WX  = 3'b000, M_WH  = 3'b010, M_HW  = 3'b101;

  localparam logic signed [ACW-1:0] ONE  = ACW'(1);
  localparam logic signed [ACW-1:0] HALF = ONE <<< (FW - 1);
`ifdef RNN_HTANH_EN
  localparam logic signed [ACW-1:0] HI = ONE <<< FW;
  localparam logic signed [ACW-1:0] LO = -(ONE <<< FW);
`else
  localparam logic signed [ACW-1:0] HI = (ONE <<< (DW - 1)) - ONE;
  localparam logic signed [ACW-1:0] LO = -(ONE <<< (DW - 1));
`endif

  logic [3:0]             state;
  logic [DW-1:0]          t_len, t;
  logic [KB-1:0]          h;
  logic [CB-1:0]          cnt;
  logic [XW-1:0]          x;
  logic signed [DW-1:0]   h_old [HID];
  logic signed [DW-1:0]   h_new [HID];
  logic signed [ACW-1:0]  acc;

  // Describes the read issued last cycle, whose data is on mdata_r now.
  logic                   pend_vld;
  logic [2:0]             pend_sel;
  logic [CB-1:0]          pend_idx;

  logic signed [2*DW-1:0] mr_ext, ho_ext, prod;
  logic signed [ACW-1:0]  bias_ext, term, sum, rnd;
  logic [DW-1:0]          act_y;
  logic                   rd_state;
  logic                   idata_unused;

  assign idata_unused = ^idata;
  assign rd_state = (state == S_BIAS) || (state == S_WX) || (state == S_WH);

  always_comb begin
    mr_ext   = {{DW{mdata_r[DW-1]}}, mdata_r};
    ho_ext   = {{DW{h_old[pend_idx[KB-1:0]][DW-1]}}, h_old[pend_idx[KB-1:0]]};
    prod     = mr_ext * ho_ext;
    bias_ext = {{(ACW-DW){mdata_r[DW-1]}}, mdata_r};
    term     = '0;
    if (pend_vld) begin
      case (pend_sel)
        M_BIH, M_BHH: term = bias_ext <<< FW;
        M_WX:         if (x[pend_idx[XB-1:0]]) term = bias_ext <<< FW;
        M_WH:         term = {{(ACW-2*DW){prod[2*DW-1]}}, prod};
        default:      term = '0;
      endcase
    end
    sum = acc + term;
    // Round half up, then drop the extra fraction bits of the Q.2FW sum.
    rnd = (sum + HALF) >>> FW;
    if (rnd > HI)      act_y = HI[DW-1:0];
    else if (rnd < LO) act_y = LO[DW-1:0];
    else               act_y = rnd[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      i_en     <= 1'b0;
      mce      <= 1'b0;
      maddr    <= '0;
      mdata_w  <= '0;
      msel     <= M_LEN;
      t_len    <= '0;
      t        <= '0;
      h        <= '0;
      cnt      <= '0;
      x        <= '0;
      acc      <= '0;
      pend_vld <= 1'b0;
      pend_sel <= M_LEN;
      pend_idx <= '0;
      for (int unsigned i = 0; i < HID; i++) begin
        h_old[i] <= '0;
        h_new[i] <= '0;
      end
    end else begin
      i_en     <= 1'b0;
      pend_vld <= rd_state;
      pend_sel <= msel;
      pend_idx <= cnt;
      acc      <= rd_state ? sum : '0;
      case (state)
        S_IDLE: if (ready) begin
          state <= S_LDT;
          busy  <= 1'b1;
          mce   <= 1'b1;
          msel  <= M_LEN;
          maddr <= '0;
        end
        S_LDT: state <= S_LDW;
        S_LDW: begin
          t_len <= mdata_r;
          if (mdata_r == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            mce   <= 1'b0;
          end else begin
            t     <= '0;
            h     <= '0;
            h_old <= h_new;
            i_en  <= 1'b1;
            state <= S_XIN;
          end
        end
        S_CPY: begin
          h_old <= h_new;
          i_en  <= 1'b1;
          state <= S_XIN;
        end
        S_XIN: begin
          x     <= idata[XW-1:0];
          cnt   <= '0;
          msel  <= M_BIH;
          maddr <= AW'(h);
          state <= S_BIAS;
        end
        S_BIAS: begin
          if (cnt == '0) begin
            cnt  <= CB'(1);
            msel <= M_BHH;
          end else begin
            cnt   <= '0;
            msel  <= M_WX;
            maddr <= AW'({h, XB'(0)});
            state <= S_WX;
          end
        end
        S_WX: begin
          if (cnt[XB-1:0] == XB'(XW - 1)) begin
            cnt <= '0;
            if (t != '0) begin
              msel  <= M_WH;
              maddr <= AW'({h, KB'(0)});
              state <= S_WH;
            end else begin
              state <= S_RND;
            end
          end else begin
            cnt   <= cnt + 1'b1;
            maddr <= AW'({h, XB'(cnt + 1'b1)});
          end
        end
        S_WH: begin
          if (cnt[KB-1:0] == KB'(HID - 1)) begin
            cnt   <= '0;
            state <= S_RND;
          end else begin
            cnt   <= cnt + 1'b1;
            maddr <= AW'({h, KB'(cnt + 1'b1)});
          end
        end
        S_RND: begin
          mdata_w <= act_y;
          msel    <= M_HW;
          maddr   <= AW'({t, h});
          state   <= S_WR;
        end
        S_WR: begin
          h_new[h] <= mdata_w;
          if (h != KB'(HID - 1)) begin
            h     <= h + 1'b1;
            msel  <= M_BIH;
            maddr <= AW'(KB'(h + 1'b1));
            state <= S_BIAS;
          end else if (t != t_len - DW'(1)) begin
            t     <= t + 1'b1;
            h     <= '0;
            state <= S_CPY;
          end else begin
            busy  <= 1'b0;
            mce   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_cell_engine.sv
// Testbench for rnn_cell_engine at HID=2, XW=4, DW=20, FW=16.
// Behavioural synchronous memory supplies length/biases/weights; every
// result write is popped from a queue of expected {address, data} pairs.
module tb_rnn_cell_engine;
  localparam int HID = 2, XW = 4, DW = 20, FW = 16, AW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic [31:0]   idata = '0;
  logic [DW-1:0] mdata_r = '0;
  logic          busy, i_en, mce;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_w;
  logic [2:0]    msel;

  rnn_cell_engine #(.HID(HID), .XW(XW), .DW(DW), .FW(FW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .idata(idata),
    .mdata_r(mdata_r), .busy(busy), .i_en(i_en), .mce(mce),
    .maddr(maddr), .mdata_w(mdata_w), .msel(msel)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] tlen;
  logic [DW-1:0] bih [HID];
  logic [DW-1:0] bhh [HID];
  logic [DW-1:0] wx  [HID][XW];
  logic [DW-1:0] wh  [HID][HID];

  always @(posedge clk) begin
    if (mce) begin
      case (msel)
        3'b100: mdata_r <= tlen;
        3'b001: mdata_r <= bih[maddr[0]];
        3'b011: mdata_r <= bhh[maddr[0]];
        3'b000: mdata_r <= wx[maddr[2]][maddr[1:0]];
        3'b010: mdata_r <= wh[maddr[1]][maddr[0]];
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         exp_q [$];
  logic [31:0] xin_q [$];
  int          wr_cyc [$];
  int          total = 0, bad = 0;
  int          cyc = 0, nwr = 0, nrd = 0;
  logic [2:0]  prev_msel = 3'b100;
  logic        prev_rd = 1'b0;
  wr_t         e;

  always @(posedge clk) cyc++;

  // Input responder and write/read monitor; a write is the first cycle of
  // msel=101 (msel holds its value between accesses).
  always @(negedge clk) begin
    if (i_en) idata = (xin_q.size() > 0) ? xin_q.pop_front() : '0;
    if (mce && msel == 3'b100 && !prev_rd) nrd++;
    if (mce && msel == 3'b101 && prev_msel != 3'b101) begin
      wr_cyc.push_back(cyc);
      nwr++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%h/%h expected=none", maddr, mdata_w);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        assert ({maddr, mdata_w} === {e.a, e.d}) else begin
          bad++;
          $error("FAIL write observed=@%0h:%h expected=@%0h:%h", maddr, mdata_w, e.a, e.d);
        end
      end
    end
    prev_msel = msel;
    prev_rd   = mce && (msel == 3'b100);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.a = AW'(a);
    w.d = DW'(d);
    exp_q.push_back(w);
  endtask

  task automatic clr_mem();
    tlen = '0;
    foreach (bih[i]) begin bih[i] = '0; bhh[i] = '0; end
    foreach (wx[i, j]) wx[i][j] = '0;
    foreach (wh[i, k]) wh[i][k] = '0;
  endtask

  task automatic run(input string tag);
    int n;
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    check({tag, "_start_busy"}, 32'(busy), 1);
    check({tag, "_start_msel"}, 32'(msel), 3'b100);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(busy), 0);
    check({tag, "_sb_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, nb, ni, n;
    clr_mem();
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_ien", 32'(i_en), 0);
    check("rst_mce", 32'(mce), 0);
    check("rst_maddr", 32'(maddr), 0);
    check("rst_mdata_w", 32'(mdata_w), 0);
    check("rst_msel", 32'(msel), 3'b100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Zero length: one length read, two busy cycles, nothing else.
    clr_mem();
    w0 = nwr; r0 = nrd;
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    nb = 0; ni = 0;
    repeat (8) begin
      if (busy) nb++;
      if (i_en) ni++;
      @(negedge clk);
    end
    check("zl_busy_cycles", 32'(nb), 2);
    check("zl_ien", 32'(ni), 0);
    check("zl_reads", 32'(nrd - r0), 1);
    check("zl_writes", 32'(nwr - w0), 0);

    // Single step, x=0101 with upper idata bits set (ignored).
    clr_mem();
    tlen = 1; bih[0] = 20'h08000;
    wx[0][0] = 20'h10000; wx[0][1] = 20'h10000; wx[0][2] = 20'h08000;
    xin_q.push_back(32'hFFFF_FFF5);
`ifdef RNN_HTANH_EN
    push_wr(0, 'h10000);
`else
    push_wr(0, 'h20000);
`endif
    push_wr(1, 0);
    w0 = nwr;
    run("single");
    check("single_nwr", 32'(nwr - w0), 2);
    check("single_neuron_cycles", 32'(wr_cyc[w0+1] - wr_cyc[w0]), 8);

    // Recurrence: h_1[1] = -0.5 * h_0[0] = -0.25.
    clr_mem();
    tlen = 2; bih[0] = 20'h08000; wh[1][0] = 20'hF8000;
    xin_q.push_back(0); xin_q.push_back(0);
    push_wr(0, 'h08000); push_wr(1, 0);
    push_wr(2, 'h08000); push_wr(3, 'hFC000);
    w0 = nwr;
    run("recur");
    check("recur_nwr", 32'(nwr - w0), 4);
    check("recur_step1_cycles", 32'(wr_cyc[w0+3] - wr_cyc[w0+2]), 10);

    // Rounding: product of exactly +/- half an LSB.
    clr_mem();
    tlen = 2; wx[0][0] = 20'h00001; wh[0][0] = 20'h08000;
    xin_q.push_back(32'h1); xin_q.push_back(0);
    push_wr(0, 1); push_wr(1, 0); push_wr(2, 1); push_wr(3, 0);
    run("round_pos");
    wh[0][0] = 20'hF8000;
    xin_q.push_back(32'h1); xin_q.push_back(0);
    push_wr(0, 1); push_wr(1, 0); push_wr(2, 0); push_wr(3, 0);
    run("round_neg");

    // Saturation / clipping at both ends.
    clr_mem();
    tlen = 1; bih[0] = 20'h7FFFF; bhh[0] = 20'h7FFFF;
    xin_q.push_back(0);
`ifdef RNN_HTANH_EN
    push_wr(0, 'h10000);
`else
    push_wr(0, 'h7FFFF);
`endif
    push_wr(1, 0);
    run("sat_pos");
    bih[0] = 20'h80000; bhh[0] = 20'h80000;
    xin_q.push_back(0);
`ifdef RNN_HTANH_EN
    push_wr(0, 'hF0000);
`else
    push_wr(0, 'h80000);
`endif
    push_wr(1, 0);
    run("sat_neg");

    // Reset asserted during WX: outputs clear without a clock edge and
    // the aborted run never writes.
    clr_mem();
    tlen = 1; bih[0] = 20'h01000;
    xin_q.push_back(32'hF);
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    n = 0;
    while (!(busy && msel == 3'b000) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_wx", 32'(msel), 3'b000);
    #1 reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_ien", 32'(i_en), 0);
    check("mid_mce", 32'(mce), 0);
    check("mid_maddr", 32'(maddr), 0);
    check("mid_mdata_w", 32'(mdata_w), 0);
    check("mid_msel", 32'(msel), 3'b100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    w0 = nwr;
    repeat (30) @(negedge clk);
    check("mid_no_write", 32'(nwr - w0), 0);
    check("mid_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
